onehot_rr_arbiter: RTL and testbench
====================================

# onehot_rr_arbiter

Round-robin arbiter that grants one of ten requesters and presents the grant as a registered 16-bit one-hot vector. Only bit positions 6..15 are used, so requester k (0..9) maps to bit k+6. The vector feeds the team's one-hot priority encoder directly, which converts it to owner ID k+1 (1..10). The block guarantees the encoder's precondition: the grant vector is either all-zero or exactly one-hot.

## Interface

- MAX_HOLD, default 15: maximum cycles a grant may stay visible before forced release. 0 disables the timeout. Legal range 0..255.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- req_i  input  10  request lines. req_i[k] is requester k.
- done_i  input  1  current owner releases its grant. Sampled only in GRANT.
- grant_onehot_o  output  16  registered grant. Bit k+6 is set for requester k. Bits 5:0 are always 0. At most one bit is set.
- grant_valid_o  output  1  high exactly when grant_onehot_o is non-zero.
- timeout_o  output  1  one-cycle pulse, coincident with the cycle the grant clears because of a forced release.

## Operation

- State machine with two states: IDLE and GRANT. State changes only on the clk edge.
- Registers:
  - ptr, 4 bits, range 0..9: highest-priority requester.
  - owner, 4 bits.
  - hold_cnt, 8 bits.
  - state.
- IDLE behaviour:
  - If req_i is non-zero, choose the first set index searching ptr, ptr+1, …, 9, 0, …, ptr-1 (modulo 10).
  - owner ← chosen index, grant_onehot_o ← 1<<(owner+6), hold_cnt ← 0, move to GRANT.
  - If req_i is zero, stay in IDLE with outputs 0.
- GRANT: a release condition is evaluated each cycle, in this priority order:
  1. done_i = 1 → normal release.
  2. req_i[owner] = 0 → normal release (requester withdrew).
  3. MAX_HOLD ≠ 0 and hold_cnt = MAX_HOLD-1 → forced release. Drive timeout_o = 1 on the next cycle.
  4. Otherwise hold_cnt ← hold_cnt+1. grant_onehot_o is held bit-stable.
- On any release:
  - grant_onehot_o ← 0, grant_valid_o ← 0.
  - ptr ← owner+1, wrapping 9→0.
  - Move to IDLE.
- Requests from non-owners never affect the current grant.
- Changes to req_i other than req_i[owner] are ignored in GRANT.
- done_i is ignored in IDLE.
- rst, whether asserted mid-grant or at any time, on the next edge forces:
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
  - All outputs 0.
  - rst has priority over all other inputs.

## Timing

- Reset values: grant_onehot_o=16'h0000, grant_valid_o=0, timeout_o=0.
- Grant latency: req_i sampled in IDLE at edge n → grant visible after edge n (1 cycle).
- Release latency: done_i, or the owner's request drop, sampled at edge m → grant cleared after edge m.
- After any release, one cycle of IDLE always follows. The earliest next grant is visible after edge m+1, so there are no back-to-back grants.
- Timeout: the grant is visible for exactly MAX_HOLD cycles. The cycle in which the grant first reads 0 carries timeout_o=1 for that single cycle.
- If done_i=1 in the same cycle as a timeout would occur, it is a normal release and timeout_o stays 0.
- With MAX_HOLD=1, every grant lasts exactly one cycle unless released earlier.
- The one-hot invariant holds every cycle, including the cycle after rst.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- Reset: hold rst for 3 cycles with req_i=10'h3FF → all outputs 0. Release rst; the first grant is requester 0: grant_onehot_o=16'h0040 one cycle later.
- Single request: req_i=10'b0000001000, done_i pulsed 5 cycles after the grant appears → grant_onehot_o=16'h0200 for exactly 5 cycles, then 0. The downstream encoder reads 4 throughout the grant.
- Round-robin wrap: req_i=10'h3FF held, done_i pulsed 1 cycle after each grant → grants 16'h0040, 0080, …, 8000, then 16'h0040 again, each separated by one idle cycle. timeout_o never asserts.
- Timeout (MAX_HOLD=4): req_i[9] held with no done_i → 16'h8000 is visible for 4 cycles, then 0 with timeout_o=1 for 1 cycle. The next grant goes to requester 0 if it is requesting.
- Collision: in the 4th grant cycle with MAX_HOLD=4, assert done_i → release with timeout_o=0. Separately, drop req_i[owner] mid-grant → release on the next edge and ptr advances.
- Reset mid-grant: assert rst while grant=16'h0100 → grant=0 after the edge. After rst deasserts, with req_i=10'h3FF, the first grant is 16'h0040 because ptr was reset to 0.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//
// Round-robin arbiter over ten requesters. The grant is a registered 16-bit
// one-hot vector where requester k drives bit k+6 (bits 5:0 are always 0), so a
// downstream one-hot priority encoder reads owner ID k+1. The vector is always
// either all-zero or exactly one-hot.
//
// Handshake: a requester holds req_i[k] high while it wants the resource. Once
// grant_onehot_o shows its bit, it keeps ownership until it pulses done_i,
// drops its own request, or holds for MAX_HOLD cycles (forced release, flagged
// by a one-cycle timeout_o pulse in the first cycle the grant reads 0). Every
// release is followed by at least one idle cycle.
//
// Parameters:
//   MAX_HOLD        maximum visible grant length in cycles, 0 disables (0..255)
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   req_i[9:0]      request lines, req_i[k] is requester k
//   done_i          owner releases its grant (only looked at while granting)
//   grant_onehot_o  registered one-hot grant, bit k+6 for requester k
//   grant_valid_o   high exactly when grant_onehot_o is non-zero
//   timeout_o       one-cycle pulse when a grant clears by forced release
//   state_dbg       current FSM state (0 = IDLE, 1 = GRANT)

module onehot_rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  req_i,
  input  logic        done_i,
  output logic [15:0] grant_onehot_o,
  output logic        grant_valid_o,
  output logic        timeout_o,
  output logic        state_dbg
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit          HOLD_EN     = (MAX_HOLD != 0);
  localparam int          HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_LAST_I);

  state_t      state, state_next;
  logic [3:0]  ptr, ptr_next;
  logic [3:0]  owner, owner_next;
  logic [7:0]  hold_cnt, hold_next;
  logic [15:0] grant_q, grant_next;
  logic        valid_q, valid_next;
  logic        timeout_q, timeout_next;

  // Round-robin search: first requester at or after ptr, wrapping mod 10.
  logic [3:0]  pick;
  logic        found;
  logic [4:0]  idx;

  always_comb begin
    pick  = 4'd0;
    found = 1'b0;
    idx   = 5'd0;
    for (int i = 0; i < 10; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= 5'd10) idx = idx - 5'd10;
      if (!found && req_i[idx[3:0]]) begin
        found = 1'b1;
        pick  = idx[3:0];
      end
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    owner_next   = owner;
    hold_next    = hold_cnt;
    grant_next   = grant_q;
    valid_next   = valid_q;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_next = pick;
          grant_next = 16'd64 << pick;
          valid_next = 1'b1;
          hold_next  = 8'd0;
          state_next = GRANT;
        end else begin
          grant_next = 16'd0;
          valid_next = 1'b0;
        end
      end
      GRANT: begin
        if (done_i || !req_i[owner] || (HOLD_EN && hold_cnt == HOLD_LAST)) begin
          grant_next   = 16'd0;
          valid_next   = 1'b0;
          ptr_next     = (owner == 4'd9) ? 4'd0 : owner + 4'd1;
          state_next   = IDLE;
          // Only a release with neither normal cause counts as a timeout.
          timeout_next = !done_i && req_i[owner];
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 16'd0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      owner     <= 4'd0;
      hold_cnt  <= 8'd0;
      grant_q   <= 16'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      hold_cnt  <= hold_next;
      grant_q   <= grant_next;
      valid_q   <= valid_next;
      timeout_q <= timeout_next;
    end
  end

  assign grant_onehot_o = grant_q;
  assign grant_valid_o  = valid_q;
  assign timeout_o      = timeout_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed testbench for onehot_rr_arbiter. Two instances share inputs:
// dut_a uses the default MAX_HOLD (15), dut_b uses MAX_HOLD = 4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_onehot_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  req;
  logic        done;

  logic [15:0] ga, gb;
  logic        va, vb, ta, tb_t, sa, sb;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [15:0] exp_q[$];

  onehot_rr_arbiter dut_a (
    .clk(clk), .rst(rst), .req_i(req), .done_i(done),
    .grant_onehot_o(ga), .grant_valid_o(va), .timeout_o(ta), .state_dbg(sa)
  );

  onehot_rr_arbiter #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req_i(req), .done_i(done),
    .grant_onehot_o(gb), .grant_valid_o(vb), .timeout_o(tb_t), .state_dbg(sb)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    done = 1'b0;
    step();
    rst  = 1'b0;
  endtask

  // Reference model of the downstream one-hot encoder: bit k+6 -> ID k+1.
  function automatic logic [15:0] enc(input logic [15:0] g);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 6; i < 16; i++)
      if (g[i]) r = 16'(i - 5);
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariant: bits 5:0 clear, at most one bit, valid tracks grant,
  // and a timeout pulse only appears while the grant reads 0.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ((ga[5:0] === 6'd0) && $onehot0(ga) && (va === (|ga)) && !(ta && (|ga))) else begin
        errors++;
        $error("FAIL inv_a: observed grant %h valid %b timeout %b", ga, va, ta);
      end
      checks++;
      assert ((gb[5:0] === 6'd0) && $onehot0(gb) && (vb === (|gb)) && !(tb_t && (|gb))) else begin
        errors++;
        $error("FAIL inv_b: observed grant %h valid %b timeout %b", gb, vb, tb_t);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 10'h3FF;
    done = 1'b0;

    // Reset held 3 cycles with all requests high
    for (int i = 0; i < 3; i++) begin
      step();
      mon_en = 1'b1;
      check("rst_grant", ga, 16'h0000);
      check("rst_valid", 16'(va), 16'd0);
      check("rst_timeout", 16'(ta), 16'd0);
      check("rst_state", 16'(sa), 16'd0);
    end
    rst = 1'b0;
    step();
    check("first_grant_a", ga, 16'h0040);
    check("first_grant_b", gb, 16'h0040);
    check("first_valid", 16'(va), 16'd1);
    req = 10'h000;
    step();
    check("withdraw_release", ga, 16'h0000);
    step();
    check("idle_no_req", ga, 16'h0000);

    // Single request, done after 5 visible cycles
    do_reset();
    req = 10'b0000001000;
    step();
    check("single_c1", ga, 16'h0200);
    check("single_enc_c1", enc(ga), 16'd4);
    for (int i = 2; i <= 5; i++) begin
      step();
      check("single_hold", ga, 16'h0200);
      check("single_enc", enc(ga), 16'd4);
    end
    done = 1'b1;
    req  = 10'h000;
    step();
    done = 1'b0;
    check("single_release", ga, 16'h0000);
    check("single_no_timeout", 16'(ta), 16'd0);

    // Round-robin wrap with all requesters active
    do_reset();
    req = 10'h3FF;
    for (int k = 0; k < 10; k++) exp_q.push_back(16'h0040 << k);
    exp_q.push_back(16'h0040);
    step();
    while (exp_q.size() > 0) begin
      check("rr_grant", ga, exp_q.pop_front());
      check("rr_timeout", 16'(ta), 16'd0);
      done = 1'b1;
      step();
      done = 1'b0;
      check("rr_idle_gap", ga, 16'h0000);
      check("rr_gap_timeout", 16'(ta), 16'd0);
      step();
    end
    req = 10'h000;
    step();

    // Timeout with MAX_HOLD = 4 on requester 9
    do_reset();
    req = 10'h200;
    step();
    check("to_c1", gb, 16'h8000);
    req = 10'h201;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("to_hold", gb, 16'h8000);
      check("to_hold_pulse", 16'(tb_t), 16'd0);
    end
    step();
    check("to_release", gb, 16'h0000);
    check("to_pulse", 16'(tb_t), 16'd1);
    step();
    check("to_next_req0", gb, 16'h0040);
    check("to_pulse_clear", 16'(tb_t), 16'd0);
    req = 10'h000;
    step();

    // Collision: done in the 4th grant cycle
    do_reset();
    req = 10'h004;
    step();
    check("col_c1", gb, 16'h0100);
    step();
    step();
    step();
    check("col_c4", gb, 16'h0100);
    done = 1'b1;
    step();
    done = 1'b0;
    check("col_release", gb, 16'h0000);
    check("col_no_timeout", 16'(tb_t), 16'd0);
    req = 10'h000;
    step();

    // Owner drops request mid-grant; ptr advances past it
    do_reset();
    req = 10'h010;
    step();
    check("drop_c1", gb, 16'h0400);
    step();
    req = 10'h021;
    step();
    check("drop_release", gb, 16'h0000);
    check("drop_no_timeout", 16'(tb_t), 16'd0);
    step();
    check("drop_ptr_adv", gb, 16'h0800);
    req = 10'h000;
    step();

    // Reset mid-grant
    do_reset();
    req = 10'h004;
    step();
    check("mid_grant", ga, 16'h0100);
    rst = 1'b1;
    req = 10'h3FF;
    step();
    check("mid_rst_grant", ga, 16'h0000);
    check("mid_rst_valid", 16'(va), 16'd0);
    rst = 1'b0;
    step();
    check("mid_after_rst", ga, 16'h0040);
    req = 10'h000;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
